// File: rtl/phold_pkg.sv
// Shared types and helpers for the PHOLD core scheduler.
// Holds the timestamp width, per-core state encoding and a timestamp minimum.
package phold_pkg;

  localparam int TW = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HELD = 2'd2
  } core_st_e;

  function automatic logic [TW-1:0] ts_min(
    input logic [TW-1:0] a,
    input logic [TW-1:0] b
  );
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/phold_core_sched_rr_arb.sv
// Combinational round-robin arbiter: first request at or after ptr wins.
// Ports: req/ptr in; one-hot gnt, winner idx and any-request flag out.
module phold_rr_arb #(
  parameter int N  = 4,
  parameter int NB = 2
) (
  input  logic [N-1:0]  req,
  input  logic [NB-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [NB-1:0] idx,
  output logic          any
);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = NB'(j);
      end
    end
  end

endmodule

// File: rtl/phold_core_sched.sv
// Scheduler between the event queue and NCORE PHOLD workers: dispatch,
// result capture, round-robin output and registered GVT broadcast.
// Ports: in_* event input handshake; core_event_* one-cycle dispatch to
// the lowest idle core; core_global_time GVT; core_new_* per-core results
// (edge detected); out_* round-robin result stream with originating core.
// Optional macro PHOLD_SCHED_STATS_EN adds stat_dispatched, stat_completed
// and stat_stall saturating 32-bit counters.
module phold_core_sched #(
  parameter int NCORE = 4,
  parameter int NCB   = 2,
  parameter int NIDB  = 3,
  parameter int TW    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NIDB-1:0]       in_id,
  input  logic [TW-1:0]         in_time,
  output logic [NCORE-1:0]      core_event_valid,
  output logic [NIDB-1:0]       core_event_id,
  output logic [TW-1:0]         core_event_time,
  output logic [TW-1:0]         core_global_time,
  input  logic [NCORE-1:0]      core_new_ready,
  input  logic [NCORE*TW-1:0]   core_new_time,
  input  logic [NCORE*NIDB-1:0] core_new_target,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [TW-1:0]         out_time,
  output logic [NIDB-1:0]       out_target,
  output logic [NCB-1:0]        out_core
`ifdef PHOLD_SCHED_STATS_EN
  ,
  output logic [31:0]           stat_dispatched,
  output logic [31:0]           stat_completed,
  output logic [31:0]           stat_stall
`endif
);

  import phold_pkg::*;

  localparam logic [NCORE-1:0] ONE = {{(NCORE-1){1'b0}}, 1'b1};

  core_st_e st_q [NCORE];
  core_st_e st_d [NCORE];

  logic [NCORE-1:0][TW-1:0]   evt_q, evt_d;
  logic [NCORE-1:0][TW-1:0]   rest_q, rest_d;
  logic [NCORE-1:0][NIDB-1:0] resg_q, resg_d;
  logic [NCORE-1:0]           nr_prev_q;

  logic [NCORE-1:0] cev_valid_q, cev_valid_d;
  logic [NIDB-1:0]  cev_id_q, cev_id_d;
  logic [TW-1:0]    cev_time_q, cev_time_d;

  logic             out_valid_q, out_valid_d;
  logic [TW-1:0]    out_time_q, out_time_d;
  logic [NIDB-1:0]  out_target_q, out_target_d;
  logic [NCB-1:0]   out_core_q, out_core_d;
  logic [NCB-1:0]   rr_q, rr_d;
  logic [TW-1:0]    gvt_q, gvt_d;

  logic [NCORE-1:0] idle, busy, held;
  logic [NCORE-1:0] disp_oh, rise, cur_oh, rel, req;
  logic [NCORE-1:0] arb_gnt;
  logic [NCB-1:0]   arb_idx;
  logic             arb_any;
  logic             in_fire, hs, load;
  logic             gvt_have;
  logic [TW-1:0]    gvt_mn;

  // Per-core state decode (output process of the per-core FSMs)
  always_comb begin
    idle = '0;
    busy = '0;
    held = '0;
    for (int k = 0; k < NCORE; k++) begin
      idle[k] = (st_q[k] == ST_IDLE);
      busy[k] = (st_q[k] == ST_BUSY);
      held[k] = (st_q[k] == ST_HELD);
    end
  end

  assign in_ready = |idle;
  assign in_fire  = in_valid & in_ready;
  // Lowest set bit of idle
  assign disp_oh  = idle & (~idle + ONE);
  assign rise     = core_new_ready & ~nr_prev_q & busy;

  assign hs     = out_valid_q & out_ready;
  assign load   = ~out_valid_q | out_ready;
  assign cur_oh = out_valid_q ? (ONE << out_core_q) : '0;
  assign rel    = hs ? cur_oh : '0;
  // The core already sitting in the output register must not win again
  assign req    = held & ~cur_oh;

  phold_rr_arb #(
    .N  (NCORE),
    .NB (NCB)
  ) u_arb (
    .req (req),
    .ptr (rr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // Next-state process
  always_comb begin
    st_d = st_q;
    for (int k = 0; k < NCORE; k++) begin
      unique case (st_q[k])
        ST_IDLE: if (in_fire && disp_oh[k]) st_d[k] = ST_BUSY;
        ST_BUSY: if (rise[k])               st_d[k] = ST_HELD;
        ST_HELD: if (rel[k])                st_d[k] = ST_IDLE;
        default:                            st_d[k] = ST_IDLE;
      endcase
    end
  end

  // Datapath
  always_comb begin
    evt_d  = evt_q;
    rest_d = rest_q;
    resg_d = resg_q;
    for (int k = 0; k < NCORE; k++) begin
      if (in_fire && disp_oh[k]) evt_d[k] = in_time;
      if (rise[k]) begin
        rest_d[k] = core_new_time[k*TW +: TW];
        resg_d[k] = core_new_target[k*NIDB +: NIDB];
      end
    end

    cev_valid_d = in_fire ? disp_oh : '0;
    cev_id_d    = in_fire ? in_id : cev_id_q;
    cev_time_d  = in_fire ? in_time : cev_time_q;

    out_valid_d  = out_valid_q;
    out_time_d   = out_time_q;
    out_target_d = out_target_q;
    out_core_d   = out_core_q;
    rr_d         = rr_q;
    if (load) begin
      out_valid_d = arb_any;
      if (arb_any) begin
        out_time_d   = '0;
        out_target_d = '0;
        for (int k = 0; k < NCORE; k++) begin
          if (arb_gnt[k]) begin
            out_time_d   = rest_q[k];
            out_target_d = resg_q[k];
          end
        end
        out_core_d = arb_idx;
        rr_d = (arb_idx == NCB'(NCORE-1)) ? '0 : arb_idx + NCB'(1);
      end
    end
  end

  // GVT: min over outstanding work, held when nothing is outstanding
  always_comb begin
    gvt_have = 1'b0;
    gvt_mn   = '1;
    for (int k = 0; k < NCORE; k++) begin
      if (busy[k]) begin
        gvt_mn   = ts_min(gvt_mn, evt_q[k]);
        gvt_have = 1'b1;
      end else if (held[k]) begin
        gvt_mn   = ts_min(gvt_mn, rest_q[k]);
        gvt_have = 1'b1;
      end
    end
    gvt_d = gvt_have ? gvt_mn : gvt_q;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCORE; k++) st_q[k] <= ST_IDLE;
      evt_q        <= '0;
      rest_q       <= '0;
      resg_q       <= '0;
      nr_prev_q    <= '0;
      cev_valid_q  <= '0;
      cev_id_q     <= '0;
      cev_time_q   <= '0;
      out_valid_q  <= 1'b0;
      out_time_q   <= '0;
      out_target_q <= '0;
      out_core_q   <= '0;
      rr_q         <= '0;
      gvt_q        <= '0;
    end else begin
      st_q         <= st_d;
      evt_q        <= evt_d;
      rest_q       <= rest_d;
      resg_q       <= resg_d;
      nr_prev_q    <= core_new_ready;
      cev_valid_q  <= cev_valid_d;
      cev_id_q     <= cev_id_d;
      cev_time_q   <= cev_time_d;
      out_valid_q  <= out_valid_d;
      out_time_q   <= out_time_d;
      out_target_q <= out_target_d;
      out_core_q   <= out_core_d;
      rr_q         <= rr_d;
      gvt_q        <= gvt_d;
    end
  end

  assign core_event_valid = cev_valid_q;
  assign core_event_id    = cev_id_q;
  assign core_event_time  = cev_time_q;
  assign core_global_time = gvt_q;
  assign out_valid        = out_valid_q;
  assign out_time         = out_time_q;
  assign out_target       = out_target_q;
  assign out_core         = out_core_q;

`ifdef PHOLD_SCHED_STATS_EN
  logic [31:0] stat_dispatched_q, stat_dispatched_d;
  logic [31:0] stat_completed_q, stat_completed_d;
  logic [31:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_dispatched_d = stat_dispatched_q;
    stat_completed_d  = stat_completed_q;
    stat_stall_d      = stat_stall_q;
    if (in_fire && (stat_dispatched_q != '1))
      stat_dispatched_d = stat_dispatched_q + 32'd1;
    if (hs && (stat_completed_q != '1))
      stat_completed_d = stat_completed_q + 32'd1;
    if (in_valid && !in_ready && (stat_stall_q != '1))
      stat_stall_d = stat_stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_dispatched_q <= '0;
      stat_completed_q  <= '0;
      stat_stall_q      <= '0;
    end else begin
      stat_dispatched_q <= stat_dispatched_d;
      stat_completed_q  <= stat_completed_d;
      stat_stall_q      <= stat_stall_d;
    end
  end

  assign stat_dispatched = stat_dispatched_q;
  assign stat_completed  = stat_completed_q;
  assign stat_stall      = stat_stall_q;
`endif

endmodule

// File: tb/tb_phold_core_sched.sv
// Self-checking bench for phold_core_sched: directed scenarios plus a
// randomized run checked against a queue-level model of the scheduler.
module tb_phold_core_sched;

  localparam int NCORE = 4;
  localparam int NCB   = 2;
  localparam int NIDB  = 3;
  localparam int TW    = 16;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  in_valid;
  logic                  in_ready;
  logic [NIDB-1:0]       in_id;
  logic [TW-1:0]         in_time;
  logic [NCORE-1:0]      core_event_valid;
  logic [NIDB-1:0]       core_event_id;
  logic [TW-1:0]         core_event_time;
  logic [TW-1:0]         core_global_time;
  logic [NCORE-1:0]      core_new_ready;
  logic [NCORE*TW-1:0]   core_new_time;
  logic [NCORE*NIDB-1:0] core_new_target;
  logic                  out_valid;
  logic                  out_ready;
  logic [TW-1:0]         out_time;
  logic [NIDB-1:0]       out_target;
  logic [NCB-1:0]        out_core;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  phold_core_sched #(
    .NCORE(NCORE), .NCB(NCB), .NIDB(NIDB), .TW(TW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_id(in_id), .in_time(in_time),
    .core_event_valid(core_event_valid),
    .core_event_id(core_event_id),
    .core_event_time(core_event_time),
    .core_global_time(core_global_time),
    .core_new_ready(core_new_ready),
    .core_new_time(core_new_time),
    .core_new_target(core_new_target),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_time(out_time), .out_target(out_target),
    .out_core(out_core)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 0; in_id = '0; in_time = '0;
    core_new_ready = '0; core_new_time = '0; core_new_target = '0;
    out_ready = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic send(input logic [NIDB-1:0] id, input logic [TW-1:0] t);
    in_valid = 1; in_id = id; in_time = t;
    tick();
    in_valid = 0;
  endtask

  task automatic pulse(input int k, input logic [TW-1:0] t,
                       input logic [NIDB-1:0] g);
    core_new_ready[k] = 1'b1;
    core_new_time[k*TW +: TW] = t;
    core_new_target[k*NIDB +: NIDB] = g;
    tick();
    core_new_ready[k] = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got=%b exp=1", in_ready); else n_pass++;
    n_chk++; if (core_event_valid !== '0) $display("FAIL rst_cev got=%b exp=0", core_event_valid); else n_pass++;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", out_valid); else n_pass++;
    n_chk++; if ({out_time, out_target, out_core} !== '0) $display("FAIL rst_out_data got=%h/%h/%h exp=0", out_time, out_target, out_core); else n_pass++;
    n_chk++; if (core_global_time !== '0) $display("FAIL rst_gvt got=%0d exp=0", core_global_time); else n_pass++;
  endtask

  task automatic test_single();
    do_reset();
    send(3'd3, 16'd100);
    n_chk++; if (core_event_valid !== 4'b0001) $display("FAIL single_cev got=%b exp=0001", core_event_valid); else n_pass++;
    n_chk++; if (core_event_id !== 3'd3 || core_event_time !== 16'd100) $display("FAIL single_evt got=%0d/%0d exp=3/100", core_event_id, core_event_time); else n_pass++;
    tick();
    n_chk++; if (core_event_valid !== 4'b0000) $display("FAIL single_pulse got=%b exp=0000", core_event_valid); else n_pass++;
    n_chk++; if (core_global_time !== 16'd100) $display("FAIL single_gvt got=%0d exp=100", core_global_time); else n_pass++;
    pulse(0, 16'd115, 3'd2);
    n_chk++; if (out_valid !== 1'b0) $display("FAIL single_early got=%b exp=0", out_valid); else n_pass++;
    tick();
    n_chk++; if (out_valid !== 1'b1 || out_time !== 16'd115 || out_target !== 3'd2 || out_core !== 2'd0)
      $display("FAIL single_out got=%b/%0d/%0d/%0d exp=1/115/2/0", out_valid, out_time, out_target, out_core); else n_pass++;
    out_ready = 1;
    tick();
    out_ready = 0;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL single_hs got=%b exp=0", out_valid); else n_pass++;
    tick();
    n_chk++; if (core_global_time !== 16'd115) $display("FAIL single_gvt_hold got=%0d exp=115", core_global_time); else n_pass++;
    send(3'd1, 16'd200);
    n_chk++; if (core_event_valid !== 4'b0001) $display("FAIL single_redisp got=%b exp=0001", core_event_valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [TW-1:0] t [5];
    logic [NCORE-1:0] one;
    int w;
    do_reset();
    out_ready = 1;
    one = 1;
    for (int i = 0; i < 5; i++) t[i] = TW'($urandom_range(1, 20000));
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_id = NIDB'(i); in_time = t[i];
      n_chk++; if (in_ready !== 1'b1) $display("FAIL b2b_ready%0d got=%b exp=1", i, in_ready); else n_pass++;
      tick();
      n_chk++; if (core_event_valid !== (one << i) || core_event_time !== t[i])
        $display("FAIL b2b_disp%0d got=%b/%0d exp=%b/%0d", i, core_event_valid, core_event_time, one << i, t[i]); else n_pass++;
    end
    in_id = 3'd4; in_time = t[4];
    n_chk++; if (in_ready !== 1'b0) $display("FAIL b2b_full got=%b exp=0", in_ready); else n_pass++;
    repeat (3) tick();
    n_chk++; if (core_event_valid !== '0 || in_ready !== 1'b0) $display("FAIL b2b_stall got=%b/%b exp=0000/0", core_event_valid, in_ready); else n_pass++;
    pulse(2, 16'd999, 3'd1);
    w = 0;
    while (!in_ready && w < 8) begin tick(); w++; end
    n_chk++; if (in_ready !== 1'b1) $display("FAIL b2b_free got=%b exp=1", in_ready); else n_pass++;
    tick();
    in_valid = 0;
    n_chk++; if (core_event_valid !== 4'b0100 || core_event_time !== t[4])
      $display("FAIL b2b_fifth got=%b/%0d exp=0100/%0d", core_event_valid, core_event_time, t[4]); else n_pass++;
  endtask

  task automatic test_rr();
    do_reset();
    for (int i = 0; i < 4; i++) send(NIDB'(i), TW'(10 + i));
    core_new_ready = 4'b1010;
    core_new_time[1*TW +: TW] = 16'd201; core_new_target[1*NIDB +: NIDB] = 3'd5;
    core_new_time[3*TW +: TW] = 16'd203; core_new_target[3*NIDB +: NIDB] = 3'd7;
    tick();
    core_new_ready = '0;
    pulse(0, 16'd200, 3'd6);
    n_chk++; if (out_valid !== 1'b1 || out_core !== 2'd1 || out_time !== 16'd201)
      $display("FAIL rr_first got=%b/%0d/%0d exp=1/1/201", out_valid, out_core, out_time); else n_pass++;
    out_ready = 1;
    tick();
    n_chk++; if (out_valid !== 1'b1 || out_core !== 2'd3 || out_time !== 16'd203 || out_target !== 3'd7)
      $display("FAIL rr_second got=%b/%0d/%0d/%0d exp=1/3/203/7", out_valid, out_core, out_time, out_target); else n_pass++;
    tick();
    n_chk++; if (out_valid !== 1'b1 || out_core !== 2'd0 || out_time !== 16'd200)
      $display("FAIL rr_third got=%b/%0d/%0d exp=1/0/200", out_valid, out_core, out_time); else n_pass++;
    tick();
    out_ready = 0;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL rr_empty got=%b exp=0", out_valid); else n_pass++;
  endtask

  task automatic test_stall();
    int w;
    int bad_data;
    int bad_disp;
    do_reset();
    send(3'd0, 16'd50);
    pulse(0, 16'd77, 3'd5);
    w = 0;
    while (!out_valid && w < 5) begin tick(); w++; end
    bad_data = 0;
    bad_disp = 0;
    in_valid = 1;
    for (int c = 0; c < 10; c++) begin
      in_time = TW'($urandom_range(100, 900));
      if (!(out_valid === 1'b1 && out_time === 16'd77 && out_target === 3'd5)) bad_data++;
      if (core_event_valid[0] !== 1'b0) bad_disp++;
      tick();
    end
    in_valid = 0;
    n_chk++; if (bad_data != 0) $display("FAIL stall_stable got=%0d bad cycles exp=0", bad_data); else n_pass++;
    n_chk++; if (bad_disp != 0) $display("FAIL stall_redisp got=%0d bad cycles exp=0", bad_disp); else n_pass++;
    n_chk++; if (in_ready !== 1'b0) $display("FAIL stall_full got=%b exp=0", in_ready); else n_pass++;
    out_ready = 1;
    tick();
    out_ready = 0;
    tick();
    n_chk++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL stall_release got=%b/%b exp=0/1", out_valid, in_ready); else n_pass++;
  endtask

  task automatic test_gvt();
    do_reset();
    send(3'd0, 16'd40);
    send(3'd1, 16'd25);
    send(3'd2, 16'd60);
    tick();
    n_chk++; if (core_global_time !== 16'd25) $display("FAIL gvt_min got=%0d exp=25", core_global_time); else n_pass++;
    pulse(1, 16'd50, 3'd3);
    tick();
    n_chk++; if (core_global_time !== 16'd40) $display("FAIL gvt_after got=%0d exp=40", core_global_time); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int w;
    do_reset();
    send(3'd0, 16'd30);
    send(3'd1, 16'd31);
    send(3'd2, 16'd32);
    pulse(2, 16'd90, 3'd4);
    w = 0;
    while (!out_valid && w < 5) begin tick(); w++; end
    in_valid = 1; in_time = 16'd33;
    tick();
    in_valid = 0;
    n_chk++; if (core_event_valid !== 4'b1000 || out_valid !== 1'b1) $display("FAIL midrst_pre got=%b/%b exp=1000/1", core_event_valid, out_valid); else n_pass++;
    #1 rst_n = 0;
    #1;
    n_chk++; if (out_valid !== 1'b0 || core_event_valid !== '0 || core_global_time !== '0)
      $display("FAIL midrst_clear got=%b/%b/%0d exp=0/0000/0", out_valid, core_event_valid, core_global_time); else n_pass++;
    #1 rst_n = 1;
    tick();
    n_chk++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL midrst_after got=%b/%b exp=1/0", in_ready, out_valid); else n_pass++;
  endtask

  task automatic test_random();
    int st [NCORE];
    logic [TW-1:0] bt [NCORE];
    logic [TW-1:0] ht [NCORE];
    logic [NIDB-1:0] hg [NCORE];
    logic [NCORE-1:0] cap;
    logic [NCORE-1:0] last_nr;
    logic [NCORE-1:0] one;
    logic [NCORE-1:0] exp_cev;
    logic [TW-1:0] egvt;
    logic [TW-1:0] mn;
    int k_exp;
    int hc;
    bit drain;
    bit fire;
    bit hs;
    bit any;
    int bad;
    do_reset();
    one = 1;
    egvt = '0;
    last_nr = '0;
    for (int k = 0; k < NCORE; k++) st[k] = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      drain = (cyc >= 340);
      k_exp = -1;
      for (int k = NCORE - 1; k >= 0; k--) if (st[k] == 0) k_exp = k;
      n_chk++; if (in_ready !== (k_exp >= 0)) $display("FAIL rnd_ready c%0d got=%b exp=%b", cyc, in_ready, k_exp >= 0); else n_pass++;
      if (out_valid) begin
        hc = int'(out_core);
        n_chk++; if (st[hc] != 2 || out_time !== ht[hc] || out_target !== hg[hc])
          $display("FAIL rnd_out c%0d got=core%0d/%0d/%0d exp=held %0d/%0d", cyc, hc, out_time, out_target, ht[hc], hg[hc]); else n_pass++;
      end
      in_valid = drain ? 1'b0 : 1'($urandom_range(0, 1));
      in_id = NIDB'($urandom);
      in_time = TW'($urandom_range(0, 30000));
      out_ready = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
      core_new_ready = '0;
      cap = '0;
      for (int k = 0; k < NCORE; k++) begin
        if (st[k] == 1 && !last_nr[k] && (drain || $urandom_range(0, 3) == 0)) begin
          cap[k] = 1'b1;
          core_new_ready[k] = 1'b1;
          core_new_time[k*TW +: TW] = TW'($urandom_range(0, 30000));
          core_new_target[k*NIDB +: NIDB] = NIDB'($urandom);
        end else if (st[k] == 0 && !drain && $urandom_range(0, 7) == 0) begin
          core_new_ready[k] = 1'b1;
        end
      end
      fire = in_valid && (k_exp >= 0);
      hs = out_valid && out_ready;
      hc = int'(out_core);
      any = 0;
      mn = '1;
      for (int k = 0; k < NCORE; k++) begin
        if (st[k] == 1) begin any = 1; if (bt[k] < mn) mn = bt[k]; end
        if (st[k] == 2) begin any = 1; if (ht[k] < mn) mn = ht[k]; end
      end
      if (any) egvt = mn;
      tick();
      exp_cev = fire ? (one << k_exp) : '0;
      n_chk++; if (core_event_valid !== exp_cev) $display("FAIL rnd_cev c%0d got=%b exp=%b", cyc, core_event_valid, exp_cev); else n_pass++;
      if (fire) begin
        n_chk++; if (core_event_id !== in_id || core_event_time !== in_time)
          $display("FAIL rnd_evt c%0d got=%0d/%0d exp=%0d/%0d", cyc, core_event_id, core_event_time, in_id, in_time); else n_pass++;
      end
      n_chk++; if (core_global_time !== egvt) $display("FAIL rnd_gvt c%0d got=%0d exp=%0d", cyc, core_global_time, egvt); else n_pass++;
      if (hs) st[hc] = 0;
      for (int k = 0; k < NCORE; k++) begin
        if (cap[k]) begin
          st[k] = 2;
          ht[k] = core_new_time[k*TW +: TW];
          hg[k] = core_new_target[k*NIDB +: NIDB];
        end
      end
      if (fire) begin st[k_exp] = 1; bt[k_exp] = in_time; end
      last_nr = core_new_ready;
    end
    core_new_ready = '0;
    out_ready = 0;
    bad = 0;
    for (int k = 0; k < NCORE; k++) if (st[k] != 0) bad++;
    n_chk++; if (bad != 0 || out_valid !== 1'b0) $display("FAIL rnd_drain got=%0d busy/%b exp=0/0", bad, out_valid); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_rr();
    test_stall();
    test_gvt();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
